// File: rtl/relu_layer_scheduler.sv
// Time-multiplexed ReLU: captures a SIZE-element vector and sweeps it through LANES shared lanes, one chunk per cycle.
// Latency SIZE/LANES cycles from accept to out_valid; in_ready is low until the result is taken with out_ready.
module relu_layer_scheduler #(
  parameter int WIDTH = 16,
  parameter int NFRAC = 10,
  parameter int SIZE  = 64,
  parameter int LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    in_data [SIZE-1:0],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    out_data [SIZE-1:0],
  output logic [$clog2(SIZE+1)-1:0]  neg_count,
  output logic                       busy
);

  localparam int NCHUNK = SIZE / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int NW     = $clog2(SIZE + 1);

  if (SIZE % LANES != 0) begin : g_size_chk
    $error("relu_layer_scheduler: SIZE must be a multiple of LANES");
  end
  if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_frac_chk
    $error("relu_layer_scheduler: NFRAC must lie within WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            chunk;
  logic signed [WIDTH-1:0]  vec_buf  [SIZE-1:0];
  logic signed [WIDTH-1:0]  lane_res [LANES];
  logic [NW-1:0]            lane_neg;
  logic [IW-1:0]            base;

  // Lane i of the current chunk works on element chunk*LANES+i; decision is the sign bit alone.
  always_comb begin
    base     = IW'(int'(chunk) * LANES);
    lane_neg = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_res[i] = vec_buf[base + IW'(i)][WIDTH-1] ? '0 : vec_buf[base + IW'(i)];
      lane_neg    = lane_neg + NW'(vec_buf[base + IW'(i)][WIDTH-1]);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (chunk == CW'(NCHUNK - 1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chunk     <= '0;
      neg_count <= '0;
      vec_buf   <= '{default: '0};
      out_data  <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        vec_buf   <= in_data;
        chunk     <= '0;
        neg_count <= '0;
      end else if (state == RUN) begin
        for (int i = 0; i < LANES; i++) begin
          out_data[base + IW'(i)] <= lane_res[i];
        end
        neg_count <= neg_count + lane_neg;
        if (chunk != CW'(NCHUNK - 1)) chunk <= chunk + 1'b1;
      end
    end
  end

endmodule
